// File: rtl/mem_pkg.sv
// mem_pkg: memory op codes, stage FSM states and op classification helpers
package mem_pkg;
    typedef enum logic [3:0] {
        OP_NONE = 4'd0, LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W
    } mem_op_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3;
    function automatic logic is_load(input logic [3:0] op);
        return op inside {LD_B, LD_H, LD_W, LD_BU, LD_HU};
    endfunction
    function automatic logic is_store(input logic [3:0] op);
        return op inside {ST_B, ST_H, ST_W};
    endfunction
    function automatic logic [1:0] op_size(input logic [3:0] op);
        return op inside {LD_B, LD_BU, ST_B} ? SZ_B :
               op inside {LD_H, LD_HU, ST_H} ? SZ_H :
               op inside {LD_W, ST_W} ? SZ_W : SZ_X;
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: load lane extraction/extension, store replication, byte enables, misalignment check
module mem_align
    import mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);
    logic [1:0]  size;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        size = op_size(op);
        misaligned = (size == SZ_H && offset[0]) || (size == SZ_W && offset != 2'b00);
        wstrb = size == SZ_B ? 4'b0001 << offset : size == SZ_H ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = size == SZ_B ? {4{store_data[7:0]}} : size == SZ_H ? {2{store_data[15:0]}} : store_data;
        b = rdata[{offset, 3'b000} +: 8];
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = op == LD_B  ? {{24{b[7]}}, b} :
                    op == LD_BU ? {24'd0, b} :
                    op == LD_H  ? {{16{h[15]}}, h} :
                    op == LD_HU ? {16'd0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with req/gnt/rvalid bus FSM, flush kill and load alignment
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_inst_valid,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_inst_pc,
    input  logic [31:0] ex_instr,
    input  logic        flush,
    output logic        stall_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_inst_valid,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_inst_pc,
    output logic [31:0] mem_instr,
    output logic        mem_excp_ale
);
    state_e      state, state_n;
    logic [31:0] rdata_q, wdata, load_data;
    logic [3:0]  wstrb;
    logic        kill_q, misaligned, ld, st, is_mem, go, req, ret;

    mem_align u_align (
        .op(ex_mem_op),
        .offset(ex_mem_addr[1:0]),
        .store_data(ex_store_data),
        .rdata(rdata_q),
        .wdata(wdata),
        .wstrb(wstrb),
        .load_data(load_data),
        .misaligned(misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdata_q <= '0;
            kill_q <= 1'b0;
        end else begin
            state <= state_n;
            rdata_q <= state == WAIT && dmem_rvalid ? dmem_rdata : rdata_q;
            kill_q <= state == DONE ? 1'b0 : kill_q || (flush && (state == REQ || state == WAIT));
        end
    end

    // outputs are forced to zero while rst is high, independent of the registered state
    always_comb begin
        ld = is_load(ex_mem_op);
        st = is_store(ex_mem_op);
        is_mem = ex_inst_valid && (ld || st);
        go = state == IDLE && is_mem && !misaligned && !flush;
        state_n = state == IDLE ? (go ? (dmem_gnt ? (st ? DONE : WAIT) : REQ) : IDLE) :
                  state == REQ  ? (dmem_gnt ? (st ? DONE : WAIT) : REQ) :
                  state == WAIT ? (dmem_rvalid ? DONE : WAIT) : IDLE;
        req = !rst && (go || state == REQ);
        ret = !rst && (state == IDLE ? ex_inst_valid && !flush && (!is_mem || misaligned)
                                     : state == DONE && !kill_q && !flush);
        stall_req = req || (!rst && state == WAIT);
        dmem_req = req;
        dmem_we = req && st;
        dmem_addr = req ? {ex_mem_addr[31:2], 2'b00} : '0;
        dmem_wstrb = req ? wstrb : '0;
        dmem_wdata = req && st ? wdata : '0;
        mem_inst_valid = ret;
        mem_wd = ret ? ex_wd : '0;
        mem_wreg = ret && ex_wreg && (state == DONE ? ld : !is_mem);
        mem_wdata = !ret ? '0 : state == DONE && ld ? load_data : ex_wdata;
        mem_inst_pc = ret ? ex_inst_pc : '0;
        mem_instr = ret ? ex_instr : '0;
        mem_excp_ale = ret && state == IDLE && is_mem;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage against a spec-level reference model
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_inst_valid = 1'b0, ex_wreg = 1'b0, flush = 1'b0;
    logic [3:0]  ex_mem_op = '0;
    logic [31:0] ex_mem_addr = '0, ex_store_data = '0, ex_wdata = '0, ex_inst_pc = '0, ex_instr = '0;
    logic [4:0]  ex_wd = '0;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_req, dmem_req, dmem_we, mem_inst_valid, mem_wreg, mem_excp_ale;
    logic [31:0] dmem_addr, dmem_wdata, mem_wdata, mem_inst_pc, mem_instr;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  mem_wd;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_inst_valid(ex_inst_valid), .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
        .ex_store_data(ex_store_data), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_inst_pc(ex_inst_pc), .ex_instr(ex_instr), .flush(flush),
        .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_inst_valid(mem_inst_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_inst_pc(mem_inst_pc), .mem_instr(mem_instr),
        .mem_excp_ale(mem_excp_ale)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input int op, input int off, input logic [31:0] rd);
        int b, h;
        b = int'((rd >> (8 * off)) & 32'hFF);
        h = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
        case (op)
            1: return 32'(b > 127 ? b - 256 : b);
            2: return 32'(h > 32767 ? h - 65536 : h);
            4: return 32'(b);
            5: return 32'(h);
            default: return rd;
        endcase
    endfunction

    // one instruction from entry to retire; g = cycles without gnt, r = gnt-to-rvalid, fc = flush cycle (-1 none)
    task automatic run_txn(input logic v, input logic [3:0] op, input logic [31:0] addr, sd, alu, rd,
                           input logic [4:0] wd, input logic wreg, input int g, r, fc);
        int o, off, size, s;
        bit is_ld, is_st, mis, mem, go, ret;
        logic [31:0] pc, ins, exp_wdata, exp_sw, exp_strb;
        o = int'(op);
        off = int'(addr[1:0]);
        is_ld = o >= 1 && o <= 5;
        is_st = o >= 6 && o <= 8;
        size = (o == 1 || o == 4 || o == 6) ? 1 : (o == 2 || o == 5 || o == 7) ? 2 : 4;
        mis = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
        mem = v && (is_ld || is_st);
        go = mem && !mis && fc != 0;
        s = !go ? 0 : is_st ? g + 1 : g + r + 1;
        ret = go ? !(fc >= 1 && fc <= s) : v && fc != 0;
        exp_wdata = go && is_ld ? ref_load(o, off, rd) : alu;
        exp_sw = size == 1 ? sd[7:0] * 32'h01010101 : size == 2 ? sd[15:0] * 32'h00010001 : sd;
        exp_strb = size == 1 ? 32'd1 << off : size == 2 ? (off >= 2 ? 32'd12 : 32'd3) : 32'd15;
        pc = $urandom;
        ins = $urandom;
        ex_inst_valid = v; ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sd;
        ex_wdata = alu; ex_wd = wd; ex_wreg = wreg; ex_inst_pc = pc; ex_instr = ins;
        for (int c = 0; c <= s; c++) begin
            flush = c == fc;
            dmem_gnt = go && c == g;
            dmem_rvalid = (go && is_ld && c == g + r) || ((c <= g || c == s) && $urandom_range(0, 1) == 1);
            dmem_rdata = go && is_ld && c == g + r ? rd : $urandom;
            @(negedge clk);
            check("stall_req", stall_req, c < s);
            check("dmem_req", dmem_req, go && c <= g);
            check("mem_inst_valid", mem_inst_valid, c == s && ret);
            if (go && c == 0) begin
                check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                check("dmem_we", dmem_we, is_st);
                if (is_st) begin
                    check("dmem_wstrb", dmem_wstrb, exp_strb);
                    check("dmem_wdata", dmem_wdata, exp_sw);
                end
            end
            if (c == s) begin
                check("mem_wd", mem_wd, ret ? wd : 5'd0);
                check("mem_wreg", mem_wreg, ret && wreg && (go ? is_ld : !mem));
                check("mem_wdata", mem_wdata, ret ? exp_wdata : 32'd0);
                check("mem_excp_ale", mem_excp_ale, ret && !go && mem);
                check("mem_inst_pc", mem_inst_pc, ret ? pc : 32'd0);
                check("mem_instr", mem_instr, ret ? ins : 32'd0);
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, stall_req, 0);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_valid"}, mem_inst_valid, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wreg"}, mem_wreg, 0);
    endtask

    initial begin
        int g, r, fc;
        rst = 1'b1;
        ex_inst_valid = 1'b1; ex_wdata = 32'h55; ex_wd = 5'd3; ex_wreg = 1'b1; dmem_gnt = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_zero("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0; dmem_gnt = 1'b0;
        run_txn(1, 4'd0, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 1, 0, 1, -1);
        run_txn(1, 4'd1, 32'h1003, 32'h0, 32'h0, 32'h80FF_0000, 5'd7, 1, 0, 1, -1);
        run_txn(1, 4'd7, 32'h2002, 32'hABCD, 32'h0, 32'h0, 5'd3, 1, 2, 1, -1);
        run_txn(1, 4'd3, 32'h3001, 32'h0, 32'h77, 32'h0, 5'd4, 1, 0, 1, -1);
        run_txn(1, 4'd5, 32'h4002, 32'h0, 32'h0, 32'hBEEF_0000, 5'd9, 1, 0, 2, 1);
        run_txn(1, 4'd0, 32'h0, 32'h0, 32'h42, 32'h0, 5'd1, 1, 0, 1, -1);
        // reset while a load waits for data, then a stale rvalid
        ex_inst_valid = 1'b1; ex_mem_op = 4'd3; ex_mem_addr = 32'h5000; dmem_gnt = 1'b1;
        @(negedge clk);
        check("rst_txn_req", dmem_req, 1);
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0; ex_inst_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_zero("stale_rvalid");
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        run_txn(1, 4'd0, 32'h0, 32'h0, 32'h99, 32'h0, 5'd2, 1, 0, 1, -1);
        run_txn(1, 4'd4, 32'h6001, 32'h0, 32'h0, 32'h1234_5678, 5'd6, 1, 1, 1, -1);
        repeat (200) begin
            g = int'($urandom_range(0, 3));
            r = int'($urandom_range(1, 3));
            fc = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, g + r + 1)) : -1;
            run_txn($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                    $urandom, 5'($urandom), 1'($urandom), g, r, fc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the LoongArch32 in-order pipeline, between the `ex_mem` register and the `mem_wb` register. It issues loads and stores to the data-memory bus through a request/grant/response handshake, and aligns and extends load data. It freezes upstream via `stall_req` while an access is outstanding and feeds `mem_wb` one retiring instruction or a bubble every cycle.

## Interface
Parameters:
- None. Widths come from the shared defines: RegAddrBus 5, RegBus 32, InstAddrBus 32, InstBus 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ex_inst_valid  in  1  upstream instruction valid
- ex_mem_op  in  4  memory op code (package enum)
- ex_mem_addr  in  32  effective address
- ex_store_data  in  32  store source register value
- ex_wd  in  5  destination register
- ex_wreg  in  1  register-write enable
- ex_wdata  in  32  ALU result
- ex_inst_pc  in  32  instruction PC
- ex_instr  in  32  instruction word
- flush  in  1  kill the current instruction
- stall_req  out  1  hold `ex_mem` and earlier stages
- dmem_req  out  1  bus request
- dmem_we  out  1  store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- mem_inst_valid  out  1  retiring instruction valid (to `mem_wb`)
- mem_wd  out  5  destination register
- mem_wreg  out  1  write enable
- mem_wdata  out  32  result
- mem_inst_pc  out  32  PC
- mem_instr  out  32  instruction
- mem_excp_ale  out  1  misaligned-address exception

## Operation
- Op codes: NONE=0, LD_B=1, LD_H=2, LD_W=3, LD_BU=4, LD_HU=5, ST_B=6, ST_H=7, ST_W=8. Codes 9–15 are treated as NONE.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0. No bus request is made. The instruction retires in the same cycle with mem_excp_ale=1 and mem_wreg=0.
- Non-memory instructions in IDLE pass straight through combinationally: mem_wdata=ex_wdata, stall_req=0.
- FSM states:
  - IDLE:
    - Valid aligned memory op: dmem_req=1, stall_req=1, outputs are a bubble.
    - gnt in this cycle: store → DONE, load → WAIT.
    - No gnt: → REQ.
  - REQ: dmem_req=1, stall_req=1. On gnt: store → DONE, load → WAIT.
  - WAIT: stall_req=1. On rvalid: capture dmem_rdata into rdata_q, → DONE.
  - DONE:
    - stall_req=0; the instruction retires; → IDLE.
    - mem_wdata = the extended rdata_q slice for loads, or ex_wdata for stores.
    - Stores retire with mem_wreg=0.
- Load extension:
  - Byte lane is selected by addr[1:0]; halfword by addr[1].
  - LD_B and LD_H sign-extend; LD_BU and LD_HU zero-extend.
- Store data:
  - ST_B: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - ST_H: wdata={2{sd[15:0]}}, wstrb=addr[1]?1100:0011.
  - ST_W: wstrb=1111.
- Bubble means mem_inst_valid=0, mem_wreg=0, mem_excp_ale=0, and every data output 0.
- Flush:
  - In IDLE: the current instruction is emitted as a bubble.
  - In REQ: a kill flag is set; the request is held until gnt.
  - In WAIT: a kill flag is set; the FSM waits for rvalid.
  - A killed instruction reaching DONE is emitted as a bubble. The kill flag clears on leaving DONE.
- Spurious input: dmem_rvalid in IDLE, REQ or DONE is ignored.

## Timing
- Reset (rst high at a clock edge):
  - FSM → IDLE; rdata_q and the kill flag cleared.
  - While rst is high, every output is 0, including dmem_req and stall_req.
  - Reset mid-transaction abandons it; a later stale rvalid is ignored.
- Latency, entry to retire:
  - Non-memory op: 0 cycles.
  - Store with immediate gnt: 1 cycle, stall_req high for 1 cycle.
  - Load with immediate gnt and rvalid the next cycle: 2 cycles, stall_req high for 2 cycles.
  - Each cycle without gnt, or gnt without rvalid, adds 1 cycle.
- Bus rule: rvalid arrives no earlier than the cycle after gnt.
- Upstream rule: `ex_*` inputs stay stable while stall_req=1.
- `mem_wb` captures the stage outputs every cycle. Stall cycles therefore deliver bubbles downstream.

## Structure
- Shared package `mem_pkg`: mem_op enum, state enum {IDLE,REQ,WAIT,DONE}, and helper functions is_load, is_store, op_size.
- Sub-module `mem_align`: combinational load extension, store replication and wstrb generation, plus the misalignment check.
- The top level holds the FSM, rdata_q, the kill flag and the output mux.

## Test plan
- ADD result 0x1234 to r5, non-memory op → same cycle: mem_inst_valid=1, mem_wd=5, mem_wdata=0x1234, stall_req=0.
- LD_B at addr 0x1003, rdata 0x80FF_0000, gnt immediate, rvalid +1 → stall for 2 cycles, then mem_wdata=0xFFFF_FF80.
- ST_H at 0x2002 with store data 0xABCD, gnt delayed 2 cycles → dmem_wstrb=1100, dmem_wdata=0xABCD_ABCD, retire with mem_wreg=0 after 3 stall cycles.
- LD_W at 0x3001 → no dmem_req, same-cycle retire with mem_excp_ale=1, mem_wreg=0.
- LD_HU at 0x4002, flush asserted in WAIT, rdata 0xBEEF_0000 → DONE emits a bubble, then FSM returns to IDLE.
- rst asserted in WAIT, then rvalid next cycle → all outputs 0, FSM IDLE, rvalid ignored.
